// File: rtl/csr_file_if.sv
`default_nettype none
// ============================================================================
// Module      : csr_file_if
// Description : Trap-port and instruction-port bundle for the machine-mode CSR
//               file; master is the core side, slave is csr_file.
// Revision    : 1.0  initial release
// ============================================================================
interface csr_file_if;
    logic        trap_write_enable;
    logic [11:0] trap_address;
    logic [31:0] trap_write_data;
    logic [31:0] trap_read_data;
    logic [1:0]  csr_op;
    logic [11:0] csr_address;
    logic [31:0] csr_write_value;
    logic [31:0] csr_read_data;
    logic        illegal_csr;
    logic        instret_pulse;

    modport master (
        output trap_write_enable, trap_address, trap_write_data,
        output csr_op, csr_address, csr_write_value, instret_pulse,
        input  trap_read_data, csr_read_data, illegal_csr
    );

    modport slave (
        input  trap_write_enable, trap_address, trap_write_data,
        input  csr_op, csr_address, csr_write_value, instret_pulse,
        output trap_read_data, csr_read_data, illegal_csr
    );
endinterface
`default_nettype wire

// File: rtl/csr_file.sv
`default_nettype none
// ============================================================================
// Module      : csr_file
// Description : RV32I machine-mode CSR file with a trap port and a Zicsr
//               instruction port. Define CSR_COUNTERS_EN to build mcycle/minstret.
// Revision    : 1.0  initial release
// ============================================================================
module csr_file #(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter logic [31:0] MHARTID     = 32'd0
) (
    input  logic        clk,
    input  logic        reset,
    csr_file_if.slave   bus
);

    localparam logic [11:0] c_MSTATUS    = 12'h300;
    localparam logic [11:0] c_MISA       = 12'h301;
    localparam logic [11:0] c_MIE        = 12'h304;
    localparam logic [11:0] c_MTVEC      = 12'h305;
    localparam logic [11:0] c_MSCRATCH   = 12'h340;
    localparam logic [11:0] c_MEPC       = 12'h341;
    localparam logic [11:0] c_MCAUSE     = 12'h342;
    localparam logic [11:0] c_MTVAL      = 12'h343;
    localparam logic [11:0] c_MIP        = 12'h344;
    localparam logic [11:0] c_MCYCLE     = 12'hB00;
    localparam logic [11:0] c_MINSTRET   = 12'hB02;
    localparam logic [11:0] c_MCYCLEH    = 12'hB80;
    localparam logic [11:0] c_MINSTRETH  = 12'hB82;
    localparam logic [11:0] c_CYCLE      = 12'hC00;
    localparam logic [11:0] c_INSTRET    = 12'hC02;
    localparam logic [11:0] c_CYCLEH     = 12'hC80;
    localparam logic [11:0] c_INSTRETH   = 12'hC82;
    localparam logic [11:0] c_MVENDORID  = 12'hF11;
    localparam logic [11:0] c_MARCHID    = 12'hF12;
    localparam logic [11:0] c_MIMPID     = 12'hF13;
    localparam logic [11:0] c_MHARTID    = 12'hF14;

    localparam logic [31:0] c_MISA_VALUE   = 32'h4000_0100;
    localparam logic [31:0] c_MSTATUS_MASK = 32'h0000_0088;
    localparam logic [31:0] c_MSTATUS_MPP  = 32'h0000_1800;
    localparam logic [31:0] c_MIE_MASK     = 32'h0000_0888;
    localparam logic [31:0] c_ALIGN_MASK   = 32'hFFFF_FFFC;
    localparam logic [31:0] c_MTVEC_INIT   = MTVEC_RESET & c_ALIGN_MASK;

    localparam logic [1:0] c_OP_NONE = 2'b00;
    localparam logic [1:0] c_OP_RW   = 2'b01;
    localparam logic [1:0] c_OP_RS   = 2'b10;
    localparam logic [1:0] c_OP_RC   = 2'b11;

    // Stored registers hold only their WARL-legal bits.
    logic [31:0] r_mstatus;
    logic [31:0] r_mie;
    logic [31:0] r_mtvec;
    logic [31:0] r_mscratch;
    logic [31:0] r_mepc;
    logic [31:0] r_mcause;
    logic [31:0] r_mtval;

    // Read views: reset values are presented while reset is asserted.
    logic [31:0] w_mstatus_v;
    logic [31:0] w_mie_v;
    logic [31:0] w_mtvec_v;
    logic [31:0] w_mscratch_v;
    logic [31:0] w_mepc_v;
    logic [31:0] w_mcause_v;
    logic [31:0] w_mtval_v;
    logic [63:0] w_mcycle_v;
    logic [63:0] w_minstret_v;

    logic        w_trap_we;
    logic [11:0] w_trap_addr;
    logic [31:0] w_trap_wdata;
    logic [1:0]  w_csr_op;
    logic [11:0] w_csr_addr;
    logic [31:0] w_csr_value;
    logic [31:0] w_csr_old;
    logic [31:0] w_csr_new;
    logic        w_suppress;
    logic        w_illegal;
    logic        w_csr_we;

    assign w_trap_we    = bus.trap_write_enable;
    assign w_trap_addr  = bus.trap_address;
    assign w_trap_wdata = bus.trap_write_data;
    assign w_csr_op     = bus.csr_op;
    assign w_csr_addr   = bus.csr_address;
    assign w_csr_value  = bus.csr_write_value;

    assign w_mstatus_v  = reset ? c_MSTATUS_MPP : (r_mstatus | c_MSTATUS_MPP);
    assign w_mie_v      = reset ? 32'd0 : r_mie;
    assign w_mtvec_v    = reset ? c_MTVEC_INIT : r_mtvec;
    assign w_mscratch_v = reset ? 32'd0 : r_mscratch;
    assign w_mepc_v     = reset ? 32'd0 : r_mepc;
    assign w_mcause_v   = reset ? 32'd0 : r_mcause;
    assign w_mtval_v    = reset ? 32'd0 : r_mtval;

    function automatic logic f_implemented(input logic [11:0] a);
        case (a)
            c_MSTATUS, c_MISA, c_MIE, c_MTVEC, c_MSCRATCH, c_MEPC, c_MCAUSE,
            c_MTVAL, c_MIP, c_MCYCLE, c_MINSTRET, c_MCYCLEH, c_MINSTRETH,
            c_CYCLE, c_INSTRET, c_CYCLEH, c_INSTRETH, c_MVENDORID, c_MARCHID,
            c_MIMPID, c_MHARTID: f_implemented = 1'b1;
            default:             f_implemented = 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] f_read(input logic [11:0] a);
        case (a)
            c_MSTATUS:              f_read = w_mstatus_v;
            c_MISA:                 f_read = c_MISA_VALUE;
            c_MIE:                  f_read = w_mie_v;
            c_MTVEC:                f_read = w_mtvec_v;
            c_MSCRATCH:             f_read = w_mscratch_v;
            c_MEPC:                 f_read = w_mepc_v;
            c_MCAUSE:               f_read = w_mcause_v;
            c_MTVAL:                f_read = w_mtval_v;
            c_MCYCLE, c_CYCLE:      f_read = w_mcycle_v[31:0];
            c_MCYCLEH, c_CYCLEH:    f_read = w_mcycle_v[63:32];
            c_MINSTRET, c_INSTRET:  f_read = w_minstret_v[31:0];
            c_MINSTRETH, c_INSTRETH: f_read = w_minstret_v[63:32];
            c_MHARTID:              f_read = MHARTID;
            default:                f_read = 32'd0;
        endcase
    endfunction

    assign w_csr_old  = f_read(w_csr_addr);
    assign w_suppress = ((w_csr_op == c_OP_RS) || (w_csr_op == c_OP_RC)) &&
                        (w_csr_value == 32'd0);
    // Read-only space is 0xC00-0xFFF; only a real write into it is illegal.
    assign w_illegal  = (w_csr_op != c_OP_NONE) &&
                        (!f_implemented(w_csr_addr) ||
                         ((w_csr_addr[11:10] == 2'b11) && !w_suppress));
    assign w_csr_we   = (w_csr_op != c_OP_NONE) && !w_illegal && !w_suppress;

    always_comb begin
        w_csr_new = w_csr_old;
        case (w_csr_op)
            c_OP_RW: w_csr_new = w_csr_value;
            c_OP_RS: w_csr_new = w_csr_old | w_csr_value;
            c_OP_RC: w_csr_new = w_csr_old & ~w_csr_value;
            default: w_csr_new = w_csr_old;
        endcase
    end

    assign bus.csr_read_data  = w_illegal ? 32'd0 : w_csr_old;
    assign bus.trap_read_data = f_read(w_trap_addr);
    assign bus.illegal_csr    = w_illegal;

    function automatic logic f_trap_hit(input logic [11:0] a);
        f_trap_hit = w_trap_we && (w_trap_addr == a);
    endfunction

    function automatic logic f_wr(input logic [11:0] a);
        f_wr = f_trap_hit(a) || (w_csr_we && (w_csr_addr == a));
    endfunction

    // On a same-address collision the trap port takes priority.
    function automatic logic [31:0] f_wdata(input logic [11:0] a);
        f_wdata = f_trap_hit(a) ? w_trap_wdata : w_csr_new;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mstatus  <= 32'd0;
            r_mie      <= 32'd0;
            r_mtvec    <= c_MTVEC_INIT;
            r_mscratch <= 32'd0;
            r_mepc     <= 32'd0;
            r_mcause   <= 32'd0;
            r_mtval    <= 32'd0;
        end else begin
            if (f_wr(c_MSTATUS))  r_mstatus  <= f_wdata(c_MSTATUS) & c_MSTATUS_MASK;
            if (f_wr(c_MIE))      r_mie      <= f_wdata(c_MIE) & c_MIE_MASK;
            if (f_wr(c_MTVEC))    r_mtvec    <= f_wdata(c_MTVEC) & c_ALIGN_MASK;
            if (f_wr(c_MSCRATCH)) r_mscratch <= f_wdata(c_MSCRATCH);
            if (f_wr(c_MEPC))     r_mepc     <= f_wdata(c_MEPC) & c_ALIGN_MASK;
            if (f_wr(c_MCAUSE))   r_mcause   <= f_wdata(c_MCAUSE);
            if (f_wr(c_MTVAL))    r_mtval    <= f_wdata(c_MTVAL);
        end
    end

`ifdef CSR_COUNTERS_EN
    logic [63:0] r_mcycle;
    logic [63:0] r_minstret;
    logic        w_mcycle_lo_wr;
    logic        w_mcycle_hi_wr;
    logic        w_minstret_lo_wr;
    logic        w_minstret_hi_wr;

    assign w_mcycle_lo_wr   = f_wr(c_MCYCLE);
    assign w_mcycle_hi_wr   = f_wr(c_MCYCLEH);
    assign w_minstret_lo_wr = f_wr(c_MINSTRET);
    assign w_minstret_hi_wr = f_wr(c_MINSTRETH);

    assign w_mcycle_v   = reset ? 64'd0 : r_mcycle;
    assign w_minstret_v = reset ? 64'd0 : r_minstret;

    // A software write to either half replaces the increment for that cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mcycle   <= 64'd0;
            r_minstret <= 64'd0;
        end else begin
            if (w_mcycle_lo_wr || w_mcycle_hi_wr) begin
                if (w_mcycle_lo_wr) r_mcycle[31:0]  <= f_wdata(c_MCYCLE);
                if (w_mcycle_hi_wr) r_mcycle[63:32] <= f_wdata(c_MCYCLEH);
            end else begin
                r_mcycle <= r_mcycle + 64'd1;
            end

            if (w_minstret_lo_wr || w_minstret_hi_wr) begin
                if (w_minstret_lo_wr) r_minstret[31:0]  <= f_wdata(c_MINSTRET);
                if (w_minstret_hi_wr) r_minstret[63:32] <= f_wdata(c_MINSTRETH);
            end else if (bus.instret_pulse) begin
                r_minstret <= r_minstret + 64'd1;
            end
        end
    end
`else
    logic w_unused_instret;

    assign w_mcycle_v       = 64'd0;
    assign w_minstret_v     = 64'd0;
    assign w_unused_instret = bus.instret_pulse;
`endif

endmodule
`default_nettype wire

// File: tb/tb_csr_file.sv
`default_nettype none
// ============================================================================
// Module      : tb_csr_file
// Description : Randomized scoreboard bench for csr_file against an
//               address-indexed reference model of the CSR rules.
// Revision    : 1.0  initial release
// ============================================================================
module tb_csr_file;

    localparam logic [31:0] MTVEC_RST = 32'h0000_1003;
    localparam logic [31:0] HART_ID   = 32'h0000_0007;
`ifdef CSR_COUNTERS_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk;
    logic reset;
    csr_file_if bus_if ();

    csr_file #(
        .MTVEC_RESET (MTVEC_RST),
        .MHARTID     (HART_ID)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit [31:0] trd;
        bit [31:0] crd;
        bit        ill;
        bit [11:0] ta;
        bit [11:0] ca;
        bit [1:0]  op;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference state: plain array indexed by CSR address plus two 64-bit counters.
    bit [31:0] m_csr [4096];
    bit [63:0] m_cycle;
    bit [63:0] m_instret;

    function automatic bit is_impl(input bit [11:0] a);
        case (a)
            12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
            12'h343, 12'h344, 12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'hC00,
            12'hC02, 12'hC80, 12'hC82, 12'hF11, 12'hF12, 12'hF13,
            12'hF14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit [31:0] wmask(input bit [11:0] a);
        case (a)
            12'h300:                   return 32'h0000_0088;
            12'h304:                   return 32'h0000_0888;
            12'h305, 12'h341:          return 32'hFFFF_FFFC;
            12'h340, 12'h342, 12'h343: return 32'hFFFF_FFFF;
            default:                   return 32'h0;
        endcase
    endfunction

    function automatic bit [31:0] m_read(input bit [11:0] a);
        case (a)
            12'h300:                   return m_csr[a] | 32'h0000_1800;
            12'h301:                   return 32'h4000_0100;
            12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
            12'h343:                   return m_csr[a];
            12'hB00, 12'hC00:          return CNT_EN ? m_cycle[31:0]    : 32'h0;
            12'hB80, 12'hC80:          return CNT_EN ? m_cycle[63:32]   : 32'h0;
            12'hB02, 12'hC02:          return CNT_EN ? m_instret[31:0]  : 32'h0;
            12'hB82, 12'hC82:          return CNT_EN ? m_instret[63:32] : 32'h0;
            12'hF14:                   return HART_ID;
            default:                   return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4096; i++) m_csr[i] = 32'h0;
        m_csr[12'h305] = MTVEC_RST & 32'hFFFF_FFFC;
        m_cycle   = 64'd0;
        m_instret = 64'd0;
    endtask

    task automatic commit(input bit [11:0] a, input bit [31:0] v,
                          inout bit [63:0] nc, inout bit [63:0] ni,
                          inout bit cw, inout bit iw);
        if (wmask(a) != 32'h0) begin
            m_csr[a] = v & wmask(a);
        end else if (CNT_EN) begin
            case (a)
                12'hB00: begin nc[31:0]  = v; cw = 1'b1; end
                12'hB80: begin nc[63:32] = v; cw = 1'b1; end
                12'hB02: begin ni[31:0]  = v; iw = 1'b1; end
                12'hB82: begin ni[63:32] = v; iw = 1'b1; end
                default: ;
            endcase
        end
    endtask

    // One clock cycle of stimulus: drive, predict the combinational outputs, advance model.
    task automatic step(input bit r, input bit twe, input bit [11:0] ta,
                        input bit [31:0] td, input bit [1:0] op,
                        input bit [11:0] ca, input bit [31:0] cv, input bit ip);
        exp_t      e;
        bit        sup, ill, cwr, cyc_w, ins_w;
        bit [31:0] old, nv;
        bit [63:0] nc, ni;
        @(posedge clk);
        #1;
        reset                    = r;
        bus_if.trap_write_enable = twe;
        bus_if.trap_address      = ta;
        bus_if.trap_write_data   = td;
        bus_if.csr_op            = op;
        bus_if.csr_address       = ca;
        bus_if.csr_write_value   = cv;
        bus_if.instret_pulse     = ip;
        if (r) model_reset();
        sup   = (op == 2'b10 || op == 2'b11) && (cv == 32'h0);
        ill   = (op != 2'b00) && (!is_impl(ca) || (ca[11:10] == 2'b11 && !sup));
        old   = m_read(ca);
        e.trd = m_read(ta);
        e.crd = ill ? 32'h0 : old;
        e.ill = ill;
        e.ta  = ta;
        e.ca  = ca;
        e.op  = op;
        sb.push_back(e);
        if (!r) begin
            case (op)
                2'b01:   nv = cv;
                2'b10:   nv = old | cv;
                2'b11:   nv = old & ~cv;
                default: nv = old;
            endcase
            cwr   = (op != 2'b00) && !ill && !sup;
            nc    = m_cycle;
            ni    = m_instret;
            cyc_w = 1'b0;
            ins_w = 1'b0;
            if (cwr) commit(ca, nv, nc, ni, cyc_w, ins_w);
            if (twe) commit(ta, td, nc, ni, cyc_w, ins_w);
            if (!cyc_w) nc = m_cycle + 64'd1;
            if (!ins_w && ip) ni = m_instret + 64'd1;
            m_cycle   = nc;
            m_instret = ni;
        end
    endtask

    // Monitor: outputs are combinational, so every driven cycle presents a response.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_vec++;
                if (bus_if.trap_read_data !== e.trd) begin
                    n_err++;
                    $display("FAIL trap_read_data vec %0d addr %h: got %h expected %h",
                             n_vec, e.ta, bus_if.trap_read_data, e.trd);
                end
                if (bus_if.csr_read_data !== e.crd) begin
                    n_err++;
                    $display("FAIL csr_read_data vec %0d op %0d addr %h: got %h expected %h",
                             n_vec, e.op, e.ca, bus_if.csr_read_data, e.crd);
                end
                if (bus_if.illegal_csr !== e.ill) begin
                    n_err++;
                    $display("FAIL illegal_csr vec %0d op %0d addr %h: got %b expected %b",
                             n_vec, e.op, e.ca, bus_if.illegal_csr, e.ill);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [11:0] pool [24] = '{
        12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
        12'h344, 12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'hC00, 12'hC02, 12'hC80,
        12'hC82, 12'hF11, 12'hF13, 12'hF14, 12'h7C0, 12'h345, 12'hB01, 12'h000
    };

    function automatic bit [31:0] rand_val();
        if ($urandom_range(0, 3) == 0) return 32'h0;
        if ($urandom_range(0, 3) == 0) return 32'hFFFF_FFFF;
        return $urandom;
    endfunction

    initial begin
        reset                    = 1'b1;
        bus_if.trap_write_enable = 1'b0;
        bus_if.trap_address      = 12'h0;
        bus_if.trap_write_data   = 32'h0;
        bus_if.csr_op            = 2'b00;
        bus_if.csr_address       = 12'h0;
        bus_if.csr_write_value   = 32'h0;
        bus_if.instret_pulse     = 1'b0;
        model_reset();

        step(1, 0, 12'h000, 0, 2'b00, 12'h000, 0, 0);
        step(1, 0, 12'h305, 0, 2'b00, 12'h300, 0, 0);
        step(0, 0, 12'h305, 0, 2'b00, 12'hB00, 0, 0);
        step(0, 0, 12'h300, 0, 2'b00, 12'hB00, 0, 0);
        // trap entry: mepc, mcause, then mtvec fetch
        step(0, 1, 12'h341, 32'h0000_0123, 2'b00, 12'h342, 0, 0);
        step(0, 1, 12'h342, 32'd11, 2'b00, 12'h341, 0, 0);
        step(0, 0, 12'h305, 0, 2'b00, 12'h342, 0, 0);
        // mstatus set / clear
        step(0, 0, 12'h341, 0, 2'b10, 12'h300, 32'hFFFF_FFFF, 0);
        step(0, 0, 12'h300, 0, 2'b11, 12'h300, 32'h0000_0008, 0);
        step(0, 0, 12'h300, 0, 2'b00, 12'h300, 0, 0);
        // same-cycle collisions
        step(0, 1, 12'h341, 32'hA0, 2'b01, 12'h341, 32'hB0, 0);
        step(0, 1, 12'h340, 32'h1, 2'b01, 12'h343, 32'h2, 0);
        step(0, 0, 12'h341, 0, 2'b00, 12'h340, 0, 0);
        step(0, 0, 12'h343, 0, 2'b01, 12'hF14, 32'd5, 0);
        step(0, 0, 12'hF14, 0, 2'b10, 12'hF14, 32'h0, 0);
        step(0, 0, 12'hF14, 0, 2'b01, 12'h7C0, 32'h1, 0);
        step(0, 0, 12'h301, 0, 2'b11, 12'hC00, 32'h0, 0);
        // counter half writes and wrap
        step(0, 0, 12'hB00, 0, 2'b01, 12'hB00, 32'hFFFF_FFFF, 0);
        step(0, 0, 12'hB80, 0, 2'b01, 12'hB80, 32'h0, 1);
        step(0, 0, 12'hB80, 0, 2'b00, 12'hB00, 0, 1);
        step(0, 0, 12'hC80, 0, 2'b00, 12'hB02, 0, 1);
        step(0, 0, 12'hB82, 0, 2'b00, 12'hC02, 0, 0);
        step(0, 1, 12'hB02, 32'hFFFF_FFFF, 2'b01, 12'hB82, 32'hFFFF_FFFF, 0);
        step(0, 0, 12'hB02, 0, 2'b00, 12'hB82, 0, 1);
        step(0, 0, 12'hC02, 0, 2'b00, 12'hC82, 0, 0);
        // reset mid trap sequence, then counter restart
        step(0, 1, 12'h341, 32'h44, 2'b00, 12'h305, 0, 0);
        step(1, 1, 12'h342, 32'h5, 2'b01, 12'h340, 32'h9, 1);
        step(0, 0, 12'h342, 0, 2'b00, 12'hB00, 0, 0);
        step(0, 0, 12'h341, 0, 2'b00, 12'hB00, 0, 0);

        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 2) == 0),
                 pool[$urandom_range(0, 23)],
                 rand_val(),
                 2'($urandom_range(0, 3)),
                 pool[$urandom_range(0, 23)],
                 rand_val(),
                 ($urandom_range(0, 1) == 1));
        end

        @(posedge clk);
        #1;
        bus_if.trap_write_enable = 1'b0;
        bus_if.csr_op            = 2'b00;
        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/csr_file.md
# csr_file

Machine-mode CSR register file for the RV32I core. It is the responder at the far end of the trap controller's CSR port: it accepts mepc/mcause writes and serves the mtvec/mepc reads that drive trap entry and return. A second port executes Zicsr instructions (CSRRW/CSRRS/CSRRC) for the execute stage. The block also owns the mcycle/minstret performance counters.

## Interface
- MTVEC_RESET, 32'h0000_0000, reset value of mtvec (bits [1:0] forced 0)
- MHARTID, 32'd0, value returned by mhartid
- clk  in  1  core clock; all state updates on posedge
- reset  in  1  synchronous, active-high; sampled at posedge clk
- trap_write_enable  in  1  trap port write strobe
- trap_address  in  12  trap port CSR address (read and write)
- trap_write_data  in  32  trap port write value
- trap_read_data  out  32  combinational read of trap_address
- csr_op  in  2  00 none, 01 RW, 10 RS (set), 11 RC (clear)
- csr_address  in  12  instruction port CSR address
- csr_write_value  in  32  rs1 value or zero-extended zimm
- csr_read_data  out  32  combinational read of csr_address (old value)
- illegal_csr  out  1  combinational; instruction access is illegal, no state change
- instret_pulse  in  1  one instruction retired this cycle

## Operation
- Implemented CSRs: mstatus 0x300, misa 0x301 (RO 32'h4000_0100), mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343, mip 0x344 (reads 0, writes ignored), mcycle 0xB00, minstret 0xB02, mcycleh 0xB80, minstreth 0xB82, cycle/instret/cycleh/instreth 0xC00/0xC02/0xC80/0xC82 (RO mirrors), mvendorid/marchid/mimpid 0xF11-0xF13 (read 0), mhartid 0xF14.
- WARL masks: mstatus keeps only MIE[3], MPIE[7]; MPP[12:11] reads 2'b11; other bits read 0. mtvec[1:0] and mepc[1:0] always read 0 (direct mode, 32-bit alignment). mie keeps bits 3, 7, 11.
- Instruction new value: RW = csr_write_value; RS = old | csr_write_value; RC = old & ~csr_write_value.
- Write suppression: RS/RC with csr_write_value == 0 performs no write and never flags a read-only violation.
- illegal_csr = 1 when csr_op != 00 and (address not implemented, or address[11:10] == 2'b11 with a write not suppressed). Illegal access commits nothing; csr_read_data returns 0.
- Trap port: writes any implemented writable address with the same WARL masks; unimplemented or read-only addresses silently ignored; never raises illegal_csr.
- Same-cycle writes: different addresses both commit; same address, trap port wins.
- Counters: mcycle increments every non-reset cycle; minstret increments when instret_pulse; both 64-bit, wrap from all-ones to 0. A software write to one half in a cycle loads that half with the written value; the other half holds (no carry, no increment that cycle).

## Timing
- Reads combinational, zero latency; reflect register state before the current edge. No write-through bypass: a value written at edge N is readable from cycle N+1.
- Trap controller sequence (write mepc, write mcause, read mtvec) needs no stall; each step completes in one cycle.
- Reset (any cycle, including mid-trap sequence): all CSRs 0 except mtvec = MTVEC_RESET & ~3; counters 0; pending writes that cycle dropped. During reset trap_read_data/csr_read_data show reset values; illegal_csr follows inputs combinationally.
- First cycle after reset release: mcycle reads 0; next cycle reads 1.

## Configuration
- CSR_COUNTERS_EN defined: mcycle/minstret and their h/user mirrors implemented as above.
- Undefined: counter addresses still legal (not illegal_csr), read 0, writes ignored; counter flops removed.

## Test plan
- Reset with MTVEC_RESET=32'h0000_1003 -> mtvec reads 32'h0000_1000; mepc, mcause, mstatus read 0; mstatus[12:11]=2'b11.
- Trap port writes mepc=32'h0000_0123 then mcause=32'd11, then reads 0x305 -> mepc reads 32'h0000_0120, mcause 11, trap_read_data = mtvec value, no illegal_csr.
- CSRRS 0x300 with 32'hFFFF_FFFF then CSRRC with 32'h0000_0008 -> reads 32'h0000_1888 then 32'h0000_1880; old value returned on each op.
- Same-cycle trap write mepc=32'hA0 and CSRRW mepc=32'hB0 -> mepc = 32'hA0; different addresses -> both committed.
- CSRRW 0xF14 value 5 -> illegal_csr=1, mhartid unchanged; CSRRS 0xF14 value 0 -> illegal_csr=0, reads MHARTID; CSRRW 0x7C0 -> illegal_csr=1.
- With CSR_COUNTERS_EN: write mcycle=32'hFFFF_FFFF, mcycleh=0 -> next cycle mcycleh=1, mcycle=0; instret_pulse for 3 cycles -> minstret +3; without macro, all counters read 0.
